// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared constants for the GEMM tile sequencer: gemm register map, DIM field layout,
// block sizes and the FSM state encoding.
package gemm_tile_sequencer_pkg;

  localparam int SUPER_SYS_ROWS = 16;
  localparam int SUPER_SYS_COLS = 16;

  localparam int BLK_N_DEF = SUPER_SYS_ROWS;
  localparam int BLK_K_DEF = SUPER_SYS_COLS;
  localparam int BLK_M_DEF = 16;

  // Offsets from the gemm register base; +0 and +24 are shared between a write and a status read
  localparam logic [31:0] REG_TILE_A   = 32'd0;
  localparam logic [31:0] REG_FULL     = 32'd0;
  localparam logic [31:0] REG_TILE_B   = 32'd4;
  localparam logic [31:0] REG_TILE_C   = 32'd8;
  localparam logic [31:0] REG_A_STRIDE = 32'd12;
  localparam logic [31:0] REG_B_STRIDE = 32'd16;
  localparam logic [31:0] REG_CTRL     = 32'd20;
  localparam logic [31:0] REG_DIM      = 32'd24;
  localparam logic [31:0] REG_DONE     = 32'd24;

  localparam int DIM_M_SH = 0;
  localparam int DIM_K_SH = 5;
  localparam int DIM_N_SH = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ASTR,
    ST_WR_BSTR,
    ST_WR_A,
    ST_WR_B,
    ST_WR_C,
    ST_WR_CTRL,
    ST_WR_DIM,
    ST_RD_FULL,
    ST_CHK_FULL,
    ST_RD_DONE,
    ST_CHK_DONE,
    ST_ZERO,
    ST_FIN
  } tile_seq_state_t;

endpackage

// File: rtl/gemm_tile_sequencer_iter.sv
// Tile-space iterator (n outer, m middle, k inner): counters, edge-tile sizes,
// first/last flags and tile addresses built from running offsets.
module gemm_tile_iter
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int BLK_N = BLK_N_DEF,
  parameter int BLK_K = BLK_K_DEF,
  parameter int BLK_M = BLK_M_DEF,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [31:0]      a_base_i,
  input  logic [31:0]      b_base_i,
  input  logic [31:0]      c_base_i,
  output logic [DIM_W-1:0] dim_k_o,
  output logic [DIM_W-1:0] dim_n_o,
  output logic [31:0]      tile_a_o,
  output logic [31:0]      tile_b_o,
  output logic [31:0]      tile_c_o,
  output logic [4:0]       msize_o,
  output logic [4:0]       ksize_o,
  output logic [4:0]       nsize_o,
  output logic             first_o,
  output logic             last_o,
  output logic             is_last_tile_o
);

  localparam int CW = DIM_W + 1;
  localparam logic [CW-1:0] STEP_M = CW'(BLK_M);
  localparam logic [CW-1:0] STEP_K = CW'(BLK_K);
  localparam logic [CW-1:0] STEP_N = CW'(BLK_N);

  logic [DIM_W-1:0] dm_q, dk_q, dn_q;
  logic [31:0]      a_base_q, b_base_q, c_base_q;
  logic [CW-1:0]    m_q, k_q, n_q;
  logic [31:0]      a_row_q, b_koff_q, c_row_q;
  logic [31:0]      a_step_q, b_step_q, c_step_q, b_tail_q, b_last_q;

  logic [CW-1:0] m_end, k_end, n_end;
  logic          last_m, last_k, last_n;

  assign m_end  = m_q + STEP_M;
  assign k_end  = k_q + STEP_K;
  assign n_end  = n_q + STEP_N;
  assign last_m = m_end >= {1'b0, dm_q};
  assign last_k = k_end >= {1'b0, dk_q};
  assign last_n = n_end >= {1'b0, dn_q};

  assign msize_o = last_m ? 5'({1'b0, dm_q} - m_q) : 5'(BLK_M);
  assign ksize_o = last_k ? 5'({1'b0, dk_q} - k_q) : 5'(BLK_K);
  assign nsize_o = last_n ? 5'({1'b0, dn_q} - n_q) : 5'(BLK_N);

  assign first_o        = (k_q == '0);
  assign last_o         = last_k;
  assign is_last_tile_o = last_k & last_m & last_n;
  assign dim_k_o        = dk_q;
  assign dim_n_o        = dn_q;

  // B points at the last K row of the tile: (K-1)*N on the final k step, else k*N + (BLK_K-1)*N
  assign tile_a_o = a_base_q + a_row_q + 32'(k_q);
  assign tile_b_o = b_base_q + (last_k ? b_last_q : (b_koff_q + b_tail_q)) + 32'(n_q);
  assign tile_c_o = c_base_q + c_row_q + 32'(n_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_q     <= '0;
      dk_q     <= '0;
      dn_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      a_row_q  <= '0;
      b_koff_q <= '0;
      c_row_q  <= '0;
      a_step_q <= '0;
      b_step_q <= '0;
      c_step_q <= '0;
      b_tail_q <= '0;
      b_last_q <= '0;
    end else if (init_i) begin
      dm_q     <= dim_m_i;
      dk_q     <= dim_k_i;
      dn_q     <= dim_n_i;
      a_base_q <= a_base_i;
      b_base_q <= b_base_i;
      c_base_q <= c_base_i;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      a_row_q  <= '0;
      b_koff_q <= '0;
      c_row_q  <= '0;
      // Step sizes are formed once per job; tiles only ever add them
      a_step_q <= 32'(dim_k_i) * 32'(BLK_M);
      b_step_q <= 32'(dim_n_i) * 32'(BLK_K);
      c_step_q <= 32'(dim_n_i) * 32'(BLK_M);
      b_tail_q <= 32'(dim_n_i) * 32'(BLK_K) - 32'(dim_n_i);
      b_last_q <= (32'(dim_k_i) - 32'd1) * 32'(dim_n_i);
    end else if (advance_i) begin
      if (!last_k) begin
        k_q      <= k_end;
        b_koff_q <= b_koff_q + b_step_q;
      end else begin
        k_q      <= '0;
        b_koff_q <= '0;
        if (!last_m) begin
          m_q     <= m_end;
          a_row_q <= a_row_q + a_step_q;
          c_row_q <= c_row_q + c_step_q;
        end else begin
          m_q     <= '0;
          a_row_q <= '0;
          c_row_q <= '0;
          n_q     <= n_end;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks a GEMM job tile by tile and programs the gemm accelerator over its system bus.
// Optional GEMM_SEQ_CYCLE_COUNT_EN adds a cycle_count output measuring job length.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int          BLK_N     = BLK_N_DEF,
  parameter int          BLK_K     = BLK_K_DEF,
  parameter int          BLK_M     = BLK_M_DEF,
  parameter int          DIM_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      c_base,
  output logic             busy,
  output logic             done,
  output logic             bus_en,
  output logic             bus_rdwr,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wr_data,
  input  logic [31:0]      bus_rd_data
`ifdef GEMM_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  tile_seq_state_t state_q, state_d;
  logic            busy_d, done_d, bus_en_d, bus_rdwr_d;
  logic [31:0]     bus_addr_d, bus_wr_data_d;
  logic            init, advance, zero_job;

  logic [DIM_W-1:0] dim_k_l, dim_n_l;
  logic [31:0]      tile_a, tile_b, tile_c;
  logic [4:0]       msize, ksize, nsize;
  logic             first, last, is_last_tile;
  logic             unused_rd_bits;

  assign unused_rd_bits = ^bus_rd_data[31:1];
  assign zero_job = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);

  gemm_tile_iter #(
    .BLK_N (BLK_N),
    .BLK_K (BLK_K),
    .BLK_M (BLK_M),
    .DIM_W (DIM_W)
  ) u_iter (
    .clk            (clk),
    .rst            (rst),
    .init_i         (init),
    .advance_i      (advance),
    .dim_m_i        (dim_m),
    .dim_k_i        (dim_k),
    .dim_n_i        (dim_n),
    .a_base_i       (a_base),
    .b_base_i       (b_base),
    .c_base_i       (c_base),
    .dim_k_o        (dim_k_l),
    .dim_n_o        (dim_n_l),
    .tile_a_o       (tile_a),
    .tile_b_o       (tile_b),
    .tile_c_o       (tile_c),
    .msize_o        (msize),
    .ksize_o        (ksize),
    .nsize_o        (nsize),
    .first_o        (first),
    .last_o         (last),
    .is_last_tile_o (is_last_tile)
  );

  always_comb begin
    state_d       = state_q;
    busy_d        = busy;
    done_d        = 1'b0;
    bus_en_d      = 1'b0;
    bus_rdwr_d    = 1'b0;
    bus_addr_d    = '0;
    bus_wr_data_d = '0;
    init          = 1'b0;
    advance       = 1'b0;

    case (state_q)
      ST_IDLE: if (start) begin
        init    = 1'b1;
        busy_d  = 1'b1;
        state_d = zero_job ? ST_ZERO : ST_WR_ASTR;
      end
      ST_WR_ASTR:  state_d = ST_WR_BSTR;
      ST_WR_BSTR:  state_d = ST_WR_A;
      ST_WR_A:     state_d = ST_WR_B;
      ST_WR_B:     state_d = ST_WR_C;
      ST_WR_C:     state_d = ST_WR_CTRL;
      ST_WR_CTRL:  state_d = ST_WR_DIM;
      ST_WR_DIM:   state_d = ST_RD_FULL;
      ST_RD_FULL:  state_d = ST_CHK_FULL;
      ST_CHK_FULL: begin
        if (bus_rd_data[0]) begin
          state_d = ST_RD_FULL;
        end else if (is_last_tile) begin
          state_d = ST_RD_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_WR_ASTR;
        end
      end
      ST_RD_DONE:  state_d = ST_CHK_DONE;
      ST_CHK_DONE: state_d = bus_rd_data[0] ? ST_FIN : ST_RD_DONE;
      ST_ZERO:     state_d = ST_FIN;
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered
    case (state_d)
      ST_WR_ASTR: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_A_STRIDE;
        bus_wr_data_d = 32'((state_q == ST_IDLE) ? dim_k : dim_k_l);
      end
      ST_WR_BSTR: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_B_STRIDE;
        bus_wr_data_d = 32'(dim_n_l);
      end
      ST_WR_A: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_TILE_A;
        bus_wr_data_d = tile_a;
      end
      ST_WR_B: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_TILE_B;
        bus_wr_data_d = tile_b;
      end
      ST_WR_C: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_TILE_C;
        bus_wr_data_d = tile_c;
      end
      ST_WR_CTRL: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_CTRL;
        bus_wr_data_d = {30'd0, first, last};
      end
      ST_WR_DIM: begin
        bus_en_d      = 1'b1;
        bus_rdwr_d    = 1'b1;
        bus_addr_d    = BASE_ADDR + REG_DIM;
        bus_wr_data_d = (32'(msize) << DIM_M_SH) | (32'(ksize) << DIM_K_SH) |
                        (32'(nsize) << DIM_N_SH);
      end
      ST_RD_FULL, ST_CHK_FULL: begin
        bus_en_d   = 1'b1;
        bus_addr_d = BASE_ADDR + REG_FULL;
      end
      ST_RD_DONE, ST_CHK_DONE: begin
        bus_en_d   = 1'b1;
        bus_addr_d = BASE_ADDR + REG_DONE;
      end
      ST_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      ST_IDLE: busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus_en      <= 1'b0;
      bus_rdwr    <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      bus_en      <= bus_en_d;
      bus_rdwr    <= bus_rdwr_d;
      bus_addr    <= bus_addr_d;
      bus_wr_data <= bus_wr_data_d;
    end
  end

`ifdef GEMM_SEQ_CYCLE_COUNT_EN
  // The accept cycle counts as the first job cycle; the count stops once busy drops at FIN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (init) begin
      cycle_count <= 32'd1;
    end else if (busy) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed self-checking bench for gemm_tile_sequencer; status reads are served from
// full_flag / done_flag, and all bus writes are logged for comparison.
module tb_gemm_tile_sequencer;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic [31:0] a_base = '0, b_base = '0, c_base = '0;
  logic        busy, done, bus_en, bus_rdwr;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
`ifdef GEMM_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  logic        full_flag = 1'b0;
  logic        done_flag = 1'b1;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd0_cnt = 0, rd24_cnt = 0, en_cnt = 0, done_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  gemm_tile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dim_m       (dim_m),
    .dim_k       (dim_k),
    .dim_n       (dim_n),
    .a_base      (a_base),
    .b_base      (b_base),
    .c_base      (c_base),
    .busy        (busy),
    .done        (done),
    .bus_en      (bus_en),
    .bus_rdwr    (bus_rdwr),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data)
`ifdef GEMM_SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  assign bus_rd_data = {31'd0, (bus_addr == BASE + 32'd24) ? done_flag : full_flag};

  always @(posedge clk) begin
    if (bus_en && bus_rdwr) begin
      wr_addr_q.push_back(bus_addr);
      wr_data_q.push_back(bus_wr_data);
    end
    if (bus_en && !bus_rdwr && bus_addr == BASE) rd0_cnt++;
    if (bus_en && !bus_rdwr && bus_addr == BASE + 32'd24) rd24_cnt++;
    if (bus_en) en_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [15:0] m, k, n, input logic [31:0] a, b, c);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd0_cnt = 0; rd24_cnt = 0; en_cnt = 0; done_cnt = 0;
    dim_m = m; dim_k = k; dim_n = n;
    a_base = a; b_base = b; c_base = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] m, k, n, input logic [31:0] a, b, c,
                         output int cycles);
    start_job(m, k, n, a, b, c);
    cycles = 1;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    $display("job M=%0d K=%0d N=%0d cycles=%0d writes=%0d", m, k, n, cycles, wr_addr_q.size());
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({busy, done, bus_en, bus_rdwr} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, bus_en, bus_rdwr});
    end
    n_cmp++;
    if (bus_addr !== 32'd0 || bus_wr_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_bus: addr %h data %h want 0", bus_addr, bus_wr_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: en %b busy %b want 0 0", bus_en, busy);
    end
  endtask

  task automatic test_single_tile;
    logic [31:0] ea[7];
    logic [31:0] ed[7];
    int cyc;
    ea = '{BASE+32'd12, BASE+32'd16, BASE, BASE+32'd4, BASE+32'd8, BASE+32'd20, BASE+32'd24};
    ed = '{32'd16, 32'd16, 32'h1000_0000, 32'h2000_00F0, 32'h3000_0000, 32'd3, 32'd16912};
    full_flag = 1'b0;
    done_flag = 1'b1;
    run_job(16'd16, 16'd16, 16'd16, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, cyc);
    n_cmp++;
    if (cyc !== 12) begin
      n_bad++;
      $display("FAIL single_cycles: got %0d want 12", cyc);
    end
`ifdef GEMM_SEQ_CYCLE_COUNT_EN
    n_cmp++;
    if (cycle_count !== 32'd12) begin
      n_bad++;
      $display("FAIL cycle_count_done: got %0d want 12", cycle_count);
    end
`endif
    n_cmp++;
    if (wr_addr_q.size() !== 7) begin
      n_bad++;
      $display("FAIL single_nwrites: got %0d want 7", wr_addr_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      if (i < wr_addr_q.size()) begin
        n_cmp++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
          n_bad++;
          $display("FAIL single_wr%0d: got %h=%h want %h=%h", i, wr_addr_q[i], wr_data_q[i],
                   ea[i], ed[i]);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL single_done_pulse: done %b busy %b pulses %0d want 0 0 1", done, busy, done_cnt);
    end
`ifdef GEMM_SEQ_CYCLE_COUNT_EN
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cycle_count !== 32'd12) begin
      n_bad++;
      $display("FAIL cycle_count_hold: got %0d want 12", cycle_count);
    end
`endif
  endtask

  task automatic test_multi_tile;
    int          idx[15];
    logic [31:0] ed[15];
    int          cyc;
    idx = '{2, 3, 5, 6, 10, 12, 37, 38, 39, 40, 41, 45, 47, 80, 83};
    ed  = '{32'h1000, 32'h100FF, 32'd2, 32'd16912, 32'h1020F, 32'd0,
            32'h12A0, 32'h10297, 32'h100110, 32'd1, 32'd16644,
            32'h1010F, 32'd2, 32'h102A7, 32'd1284};
    full_flag = 1'b0;
    done_flag = 1'b1;
    run_job(16'd20, 16'd40, 16'd17, 32'h0000_1000, 32'h0001_0000, 32'h0010_0000, cyc);
    n_cmp++;
    if (cyc !== 111) begin
      n_bad++;
      $display("FAIL multi_cycles: got %0d want 111", cyc);
    end
    n_cmp++;
    if (wr_addr_q.size() !== 84) begin
      n_bad++;
      $display("FAIL multi_nwrites: got %0d want 84", wr_addr_q.size());
    end
    for (int i = 0; i < 15; i++) begin
      if (idx[i] < wr_data_q.size()) begin
        n_cmp++;
        if (wr_data_q[idx[i]] !== ed[i]) begin
          n_bad++;
          $display("FAIL multi_wr%0d: got %h want %h", idx[i], wr_data_q[idx[i]], ed[i]);
        end
      end
    end
    if (wr_addr_q.size() == 84) begin
      n_cmp++;
      if (wr_addr_q[77] !== BASE + 32'd12 || wr_data_q[77] !== 32'd40 ||
          wr_addr_q[83] !== BASE + 32'd24) begin
        n_bad++;
        $display("FAIL multi_last_tile_hdr: got %h=%h / %h want astride 40 and DIM addr",
                 wr_addr_q[77], wr_data_q[77], wr_addr_q[83]);
      end
    end
  endtask

  task automatic test_full_backpressure;
    int cyc;
    bit released;
    full_flag = 1'b1;
    done_flag = 1'b1;
    released  = 1'b0;
    start_job(16'd16, 16'd32, 16'd16, 32'h0000_4000, 32'h0000_8000, 32'h0000_C000);
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!released && rd0_cnt >= 10) begin
        n_cmp++;
        if (wr_addr_q.size() !== 7) begin
          n_bad++;
          $display("FAIL full_stall_writes: got %0d want 7", wr_addr_q.size());
        end
        full_flag = 1'b0;
        released  = 1'b1;
      end
    end
    $display("job M=16 K=32 N=16 full-stall cycles=%0d writes=%0d", cyc, wr_addr_q.size());
    n_cmp++;
    if (cyc !== 31 || rd0_cnt !== 14) begin
      n_bad++;
      $display("FAIL full_timing: cycles %0d reads %0d want 31 14", cyc, rd0_cnt);
    end
    n_cmp++;
    if (wr_addr_q.size() !== 14) begin
      n_bad++;
      $display("FAIL full_nwrites: got %0d want 14", wr_addr_q.size());
    end else begin
      n_cmp++;
      if (wr_data_q[9] !== 32'h4010 || wr_data_q[10] !== 32'h81F0 || wr_data_q[12] !== 32'd1) begin
        n_bad++;
        $display("FAIL full_tile2: A %h B %h CTRL %h want 4010 81f0 1",
                 wr_data_q[9], wr_data_q[10], wr_data_q[12]);
      end
    end
  endtask

  task automatic test_done_poll;
    int cyc;
    full_flag = 1'b0;
    done_flag = 1'b0;
    start_job(16'd16, 16'd16, 16'd16, 32'h0, 32'h0, 32'h0);
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!done_flag && rd24_cnt >= 4) done_flag = 1'b1;
    end
    $display("job M=16 K=16 N=16 done-poll cycles=%0d reads24=%0d", cyc, rd24_cnt);
    n_cmp++;
    if (cyc !== 16 || rd24_cnt !== 6) begin
      n_bad++;
      $display("FAIL done_poll: cycles %0d reads %0d want 16 6", cyc, rd24_cnt);
    end
  endtask

  task automatic test_zero_dim;
    int cyc;
    done_flag = 1'b1;
    run_job(16'd16, 16'd0, 16'd16, 32'h1, 32'h2, 32'h3, cyc);
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++;
      $display("FAIL zero_cycles: got %0d want 2", cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (en_cnt !== 0 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL zero_traffic: en cycles %0d pulses %0d want 0 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_job;
    int t;
    int cyc;
    full_flag = 1'b0;
    done_flag = 1'b1;
    start_job(16'd16, 16'd32, 16'd16, 32'h0000_4000, 32'h0000_8000, 32'h0000_C000);
    t = 0;
    while (wr_addr_q.size() < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus_addr !== BASE + 32'd4 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_abort_state: addr %h busy %b want %h 1", bus_addr, busy, BASE + 32'd4);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bus_en, bus_rdwr} !== 4'b0000 || bus_addr !== 32'd0 || bus_wr_data !== 32'd0) begin
      n_bad++;
      $display("FAIL async_abort: flags %b addr %h data %h want all 0",
               {busy, done, bus_en, bus_rdwr}, bus_addr, bus_wr_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 0 || bus_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: pulses %0d en %b want 0 0", done_cnt, bus_en);
    end
    run_job(16'd16, 16'd32, 16'd16, 32'h0000_4000, 32'h0000_8000, 32'h0000_C000, cyc);
    n_cmp++;
    if (cyc !== 21 || wr_addr_q.size() !== 14) begin
      n_bad++;
      $display("FAIL restart_len: cycles %0d writes %0d want 21 14", cyc, wr_addr_q.size());
    end else begin
      n_cmp++;
      if (wr_data_q[2] !== 32'h4000 || wr_data_q[5] !== 32'd2) begin
        n_bad++;
        $display("FAIL restart_first_tile: A %h CTRL %h want 4000 2", wr_data_q[2], wr_data_q[5]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_tile;
    test_multi_tile;
    test_full_backpressure;
    test_done_poll;
    test_zero_dim;
    test_reset_mid_job;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Hardware replacement for the software tiling loop that drives `gemm` over its system bus.
- Accepts a full GEMM job: M, K, N, and base addresses of A, B and C in interface memory.
- Walks the tile space in n-outer, m-middle, k-inner order and writes the per-tile register set (strides, tile addresses, control, dimensions).
- Back-pressures on the accelerator FULL flag between tiles, then polls DONE and reports job completion.
- Sits between the host/CPU-side job registers and the `gemm` system-bus port.

Parameters:
- BLK_N, 16, tile width in N; equals SUPER_SYS_ROWS.
- BLK_K, 16, tile depth in K; equals SUPER_SYS_COLS.
- BLK_M, 16, tile height in M.
- DIM_W, 16, width of the M/K/N inputs.
- BASE_ADDR, 32'h9000_0000, base of the `gemm` register map.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle job request; accepted only in IDLE.
- dim_m  in  DIM_W  M.
- dim_k  in  DIM_W  K.
- dim_n  in  DIM_W  N.
- a_base  in  32  byte address of A, row-major MxK.
- b_base  in  32  byte address of B, row-major KxN.
- c_base  in  32  address of C, row-major MxN.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- bus_en  out  1  system-bus enable.
- bus_rdwr  out  1  1=write, 0=read.
- bus_addr  out  32  system-bus address.
- bus_wr_data  out  32  write data.
- bus_rd_data  in  32  read data; valid the cycle after a read is presented.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, bus_en=0, bus_rdwr=0, bus_addr=0, bus_wr_data=0. All loop counters and offsets clear. All outputs are registered.
- Register map, as offsets from BASE_ADDR:
  - +0: write TILE_A_ADDR; read FULL (bit0).
  - +4: TILE_B_ADDR.
  - +8: TILE_C_ADDR.
  - +12: A_STRIDE=K.
  - +16: B_STRIDE=N.
  - +20: CTRL = {first,last}, i.e. bit1=first, bit0=last.
  - +24: write DIM = msize | ksize<<5 | nsize<<10; read DONE (bit0).
- Start:
  - In IDLE, start=1 latches M, K, N and the three bases, then sets busy=1.
  - If any of M, K, N is 0, go straight to FIN and emit no bus traffic.
  - start while busy is ignored.
- FSM: IDLE -> WR_ASTR -> WR_BSTR -> WR_A -> WR_B -> WR_C -> WR_CTRL -> WR_DIM -> RD_FULL -> CHK_FULL -> (next tile: WR_ASTR | last tile: RD_DONE) -> CHK_DONE -> FIN -> IDLE.
  - Each WR_* state holds exactly one bus write cycle: bus_en=1, bus_rdwr=1.
  - RD_* states: bus_en=1, rdwr=0, addr=+0 or +24.
  - CHK_FULL: bus_rd_data[0]=1 -> back to RD_FULL; 0 -> advance.
  - CHK_DONE: bus_rd_data[0]=0 -> back to RD_DONE; 1 -> FIN.
  - FIN: done=1 for one cycle, busy=0, bus_en=0, then IDLE.
  - bus_en=0 only in IDLE/FIN; no idle cycles between tile writes.
- Tile sizes:
  - ksize = BLK_K if k+BLK_K<=K, else K mod BLK_K. msize and nsize are analogous.
  - An exact multiple never yields size 0.
  - first = (k==0); last = (k+BLK_K>=K).
- Tile addresses:
  - A = a_base + m*K + k.
  - B = b_base + (k+ksize-1)*N + n.
  - C = c_base + m*N + n.
  - All arithmetic is 32-bit modulo 2^32.
  - Products are formed incrementally with running offsets (add K*BLK_M or BLK_K*N per step); no multiplier in the per-tile path.
- Loop advance, after CHK_FULL clears:
  - k += BLK_K.
  - On k wrap: k=0, m += BLK_M.
  - On m wrap: m=0, n += BLK_N.
  - The tile with n, m and k all at their last values goes to RD_DONE.
- Per-tile write count: 7 writes plus at least 2 poll cycles. Minimum tile cadence is 9 cycles.
- Reset mid-job: abort immediately to IDLE. No done pulse.

Optional Feature:
- Macro: GEMM_SEQ_CYCLE_COUNT_EN.
- Defined: adds output cycle_count[31:0].
  - Clears on accepted start and increments every busy cycle.
  - Freezes at the done pulse; holds until the next start; reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Config package:
  - Register offset localparams (REG_TILE_A ... REG_DIM).
  - DIM field shifts (0/5/10).
  - State enum typedef tile_seq_state_t.
  - BLK_* defaults derived from SUPER_SYS_ROWS/COLS.
- One natural sub-module, gemm_tile_iter:
  - Holds the k/m/n counters, size and first/last calculation, and incremental address offsets.
  - Exposes an `advance` input, `is_last_tile`, and current tile fields.
  - The FSM stays in the parent.

Test Plan:
- M=K=N=16: exactly 1 tile.
  - Writes: +12=16, +16=16, +0=a_base, +4=b_base+240, +8=c_base, +20=3, +24=16|16<<5|16<<10.
  - FULL=0 -> poll +24; DONE=1 one cycle later -> done pulse.
- M=20,K=40,N=17: 2x2x3=12 tiles in n,m,k order.
  - Tile (n=0,m=16,k=32): ksize=8, msize=4, CTRL=1, A=a_base+672, B=b_base+39*17.
  - Final tile nsize=1.
- FULL held at 1 for 5 reads after tile 1: sequencer re-reads +0 each time and emits no tile-2 writes until FULL=0.
- dim_k=0 with start: no bus_en assertion; done pulses 2 cycles after start.
- rst pulled low mid-tile (during WR_B): all outputs 0 asynchronously. Next start restarts at tile (0,0,0) with first=1.
- GEMM_SEQ_CYCLE_COUNT_EN defined, 1-tile job with FULL=0 and DONE=1 on first read: cycle_count equals start-to-done cycle count (12) and holds afterwards.
